// File: rtl/fetch_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory req/gnt/rvalid bus           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage : pipelined instruction fetch feeding pipe-2 decode  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stall,
  input  wire logic        redirect,
  input  wire logic [31:0] redirect_pc,
  fetch_stage_if.master    imem,
  output logic [31:0]      pc2,
  output logic [31:0]      instr2,
  output logic             instruction_addr_misaligned2,
  output logic             valid2
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0] MAX_W = (CW+1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISAL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   disc_cnt_q, disc_cnt_d;
  logic [PW-1:0]   aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [31:0]     aq_addr_q [MAX_OUTSTANDING];

  logic [PW-1:0]   fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic [CW-1:0]   fq_cnt_q, fq_cnt_d;
  logic [31:0]     fq_pc_q    [MAX_OUTSTANDING];
  logic [31:0]     fq_instr_q [MAX_OUTSTANDING];
  logic            fq_mis_q   [MAX_OUTSTANDING];

  logic [31:0]     pc2_q, pc2_d, instr2_q, instr2_d;
  logic            valid2_q, valid2_d, mis2_q, mis2_d;

  logic            w_room, w_req, w_issue, w_pop;
  logic            w_push, w_push_mis;
  logic [31:0]     w_push_pc, w_push_instr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Admission counts buffered entries too, so every granted request has a FIFO slot.
  assign w_room    = ({1'b0, out_cnt_q} + {1'b0, fq_cnt_q}) < MAX_W;
  assign w_req     = (state_q == ST_RUN) && w_room && !rst;
  assign w_issue   = w_req && imem.gnt;
  assign w_pop     = !redirect && !stall && (fq_cnt_q != '0);
  assign imem.req  = w_req;
  assign imem.addr = fetch_pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    out_cnt_d    = out_cnt_q + CW'(w_issue) - CW'(imem.rvalid);
    disc_cnt_d   = disc_cnt_q;
    aq_wr_d      = w_issue ? ptr_inc(aq_wr_q) : aq_wr_q;
    aq_rd_d      = imem.rvalid ? ptr_inc(aq_rd_q) : aq_rd_q;
    fq_wr_d      = fq_wr_q;
    fq_rd_d      = fq_rd_q;
    w_push       = 1'b0;
    w_push_pc    = aq_addr_q[aq_rd_q];
    w_push_instr = imem.rdata;
    w_push_mis   = 1'b0;
    pc2_d        = pc2_q;
    instr2_d     = instr2_q;
    valid2_d     = valid2_q;
    mis2_d       = mis2_q;

    if (w_issue) fetch_pc_d = fetch_pc_q + 32'd4;

    if (imem.rvalid) begin
      if (disc_cnt_q != '0) disc_cnt_d = disc_cnt_q - 1'b1;
      else                  w_push     = 1'b1;
    end

    // A misaligned target is reported as a synthetic entry once the pipe is empty.
    if (state_q == ST_MISAL && out_cnt_q == '0 && fq_cnt_q == '0) begin
      w_push       = 1'b1;
      w_push_pc    = fetch_pc_q;
      w_push_instr = NOP_INSTR;
      w_push_mis   = 1'b1;
      state_d      = ST_HALT;
    end

    if (w_pop) begin
      pc2_d    = fq_pc_q[fq_rd_q];
      instr2_d = fq_instr_q[fq_rd_q];
      mis2_d   = fq_mis_q[fq_rd_q];
      valid2_d = 1'b1;
      fq_rd_d  = ptr_inc(fq_rd_q);
    end else if (redirect || !stall) begin
      instr2_d = NOP_INSTR;
      valid2_d = 1'b0;
      mis2_d   = 1'b0;
    end

    if (w_push) fq_wr_d = ptr_inc(fq_wr_q);
    fq_cnt_d = fq_cnt_q + CW'(w_push) - CW'(w_pop);

    if (redirect) begin
      w_push     = 1'b0;
      fq_cnt_d   = '0;
      fq_wr_d    = '0;
      fq_rd_d    = '0;
      disc_cnt_d = out_cnt_d;
      fetch_pc_d = redirect_pc;
      state_d    = (redirect_pc[1:0] != 2'b00) ? ST_MISAL : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      fq_cnt_q   <= '0;
      pc2_q      <= RESET_PC;
      instr2_q   <= NOP_INSTR;
      valid2_q   <= 1'b0;
      mis2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      fq_cnt_q   <= fq_cnt_d;
      pc2_q      <= pc2_d;
      instr2_q   <= instr2_d;
      valid2_q   <= valid2_d;
      mis2_q     <= mis2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) aq_addr_q[aq_wr_q] <= fetch_pc_q;
    if (w_push) begin
      fq_pc_q[fq_wr_q]    <= w_push_pc;
      fq_instr_q[fq_wr_q] <= w_push_instr;
      fq_mis_q[fq_wr_q]   <= w_push_mis;
    end
  end

  assign pc2                          = pc2_q;
  assign instr2                       = instr2_q;
  assign valid2                       = valid2_q;
  assign instruction_addr_misaligned2 = mis2_q;

  a_no_spurious_rvalid : assert property (@(posedge clk) disable iff (rst)
    !(imem.rvalid && (out_cnt_q == '0)));

endmodule
`default_nettype wire
